// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
// Holds the FSM encoding, parity-mode codes and the baud divisor table.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_e;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    // Divisor is the terminal count: a bit lasts (return value + 1) clocks.
    function automatic int unsigned baud_div(
        input logic [2:0]  sel,
        input int unsigned clk_freq
    );
        int unsigned baud;
        unique case (sel)
            3'd0:    baud = 9600;
            3'd1:    baud = 19200;
            3'd2:    baud = 38400;
            3'd3:    baud = 57600;
            default: baud = 115200;
        endcase
        return (clk_freq / baud) - 1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO with show-ahead head word.
// Occupancy counter drives Full/Empty/Level; dropped writes pulse Overflow.
module uart_tx_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_en_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     rd_en_i,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LVL_W = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [LVL_W-1:0]  lvl_q, lvl_d;
    logic              ovf_q, ovf_d;
    logic              push, pop;

    assign full_o     = (lvl_q == LVL_W'(DEPTH));
    assign empty_o    = (lvl_q == '0);
    assign level_o    = lvl_q;
    assign overflow_o = ovf_q;
    assign rd_data_o  = mem_q[rptr_q];

    assign pop  = rd_en_i && !empty_o;
    assign push = wr_en_i && (!full_o || pop);

    // Pointer, occupancy and overflow next-state.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        lvl_d  = lvl_q;
        ovf_d  = wr_en_i && full_o && !pop;
        if (push) wptr_d = wptr_q + AW'(1);
        if (pop)  rptr_d = rptr_q + AW'(1);
        unique case ({push, pop})
            2'b10:   lvl_d = lvl_q + LVL_W'(1);
            2'b01:   lvl_d = lvl_q - LVL_W'(1);
            default: lvl_d = lvl_q;
        endcase
    end

    // Control registers; reset flushes the queue.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            lvl_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            lvl_q  <= lvl_d;
            ovf_q  <= ovf_d;
        end
    end

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered UART transmitter, LSB first, run-time baud select.
// Define UART_TX_PARITY_EN to add the optional even/odd parity bit.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   Wr_en,
    input  logic [DATA_W-1:0]      Wr_data,
    input  logic [2:0]             Baud_set,
    input  logic [1:0]             Parity_mode,
    output logic                   Rs232_Tx,
    output logic                   Tx_Done,
    output logic                   UART_state,
    output logic                   Full,
    output logic                   Empty,
    output logic [$clog2(DEPTH):0] Level,
    output logic                   Overflow
);

    localparam int unsigned CNT_W = $clog2(CLK_FREQ / 9600 + 1);
    localparam int unsigned BIT_W = $clog2(DATA_W) + 1;
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    tx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              pop;
    logic              tc;
    logic [DATA_W-1:0] head;
    tx_state_e         after_data;

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_en_d;
    logic par_bit_q, par_bit_d;
    assign after_data = par_en_q ? S_PARITY : S_STOP;
`else
    logic unused_parity;
    assign unused_parity = ^Parity_mode;
    assign after_data    = S_STOP;
`endif

    uart_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i      (Clk),
        .rst_ni     (Rst_n),
        .wr_en_i    (Wr_en),
        .wr_data_i  (Wr_data),
        .rd_en_i    (pop),
        .rd_data_o  (head),
        .full_o     (Full),
        .empty_o    (Empty),
        .level_o    (Level),
        .overflow_o (Overflow)
    );

    assign tc         = (cnt_q == div_q);
    assign Rs232_Tx   = tx_q;
    assign Tx_Done    = done_q;
    assign UART_state = (state_q != S_IDLE);

    // Frame sequencing, word fetch and next line level.
    always_comb begin
        state_d = state_q;
        cnt_d   = tc ? '0 : cnt_q + CNT_W'(1);
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                pop   = !Empty;
            end
            S_START: begin
                if (tc) begin
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tc) begin
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = after_data;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (tc) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (tc) begin
                    if (bit_q == LAST_STOP) begin
                        bit_d   = '0;
                        done_d  = 1'b1;
                        pop     = !Empty;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Fetching a word latches its frame settings.
        if (pop) begin
            state_d = S_START;
            cnt_d   = '0;
            bit_d   = '0;
            shift_d = head;
            div_d   = CNT_W'(baud_div(Baud_set, CLK_FREQ));
`ifdef UART_TX_PARITY_EN
            par_en_d  = (Parity_mode == PAR_EVEN) ||
                        (Parity_mode == PAR_ODD);
            par_bit_d = (Parity_mode == PAR_ODD) ? ~^head : ^head;
`endif
        end
        unique case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_bit_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    // State and datapath registers; reset forces the line idle at once.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Per-frame parity settings.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered with a word scoreboard.
// Frames are decoded from the line and checked against queued words.
module tb_uart_tx_buffered;

    logic       Clk;
    logic       Rst_n;
    logic       Wr_en;
    logic [7:0] Wr_data;
    logic [2:0] Baud_set;
    logic [1:0] Parity_mode;
    logic       Rs232_Tx;
    logic       Tx_Done;
    logic       UART_state;
    logic       Full;
    logic       Empty;
    logic [4:0] Level;
    logic       Overflow;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic [7:0] sb [$];

    localparam int P115 = 434;
    localparam int P9K6 = 5208;

    uart_tx_buffered dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .Wr_en       (Wr_en),
        .Wr_data     (Wr_data),
        .Baud_set    (Baud_set),
        .Parity_mode (Parity_mode),
        .Rs232_Tx    (Rs232_Tx),
        .Tx_Done     (Tx_Done),
        .UART_state  (UART_state),
        .Full        (Full),
        .Empty       (Empty),
        .Level       (Level),
        .Overflow    (Overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] d, input bit push);
        Wr_data = d;
        Wr_en   = 1'b1;
        @(posedge Clk);
        #1;
        Wr_en = 1'b0;
        if (push) sb.push_back(d);
    endtask

    task automatic at_cyc(input int t);
        while (cyc < t) @(negedge Clk);
    endtask

    // Decode one frame; caller is at a negedge at or before the start bit.
    task automatic recv(input int p, input bit has_par,
                        input logic par_exp, output int wait_n);
        logic [7:0] got;
        logic [7:0] exp;
        int n;
        n = 0;
        while (Rs232_Tx !== 1'b0 && n < 60000) begin
            @(negedge Clk);
            n++;
        end
        wait_n = n;
        chk("start_seen", Rs232_Tx, 0);
        repeat (p / 2) @(negedge Clk);
        chk("start_bit", Rs232_Tx, 0);
        for (int i = 0; i < 8; i++) begin
            repeat (p) @(negedge Clk);
            got[i] = Rs232_Tx;
        end
        if (has_par) begin
            repeat (p) @(negedge Clk);
            chk("parity_bit", Rs232_Tx, par_exp);
        end
        repeat (p) @(negedge Clk);
        chk("stop_bit", Rs232_Tx, 1);
        exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        chk("data", got, exp);
        repeat (p - p / 2 - 1) @(negedge Clk);
        chk("done_early", Tx_Done, 0);
        @(negedge Clk);
        chk("done_pulse", Tx_Done, 1);
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        #1;
        chk("rst_tx", Rs232_Tx, 1);
        chk("rst_state", UART_state, 0);
        chk("rst_level", Level, 0);
        chk("rst_empty", Empty, 1);
        chk("rst_full", Full, 0);
        chk("rst_done", Tx_Done, 0);
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        sb.delete();
    endtask

    initial begin
        int w;
        int c1;
        bit seen;
        Rst_n       = 1'b1;
        Wr_en       = 1'b0;
        Wr_data     = '0;
        Baud_set    = 3'd4;
        Parity_mode = 2'd0;
        #2;
        Rst_n = 1'b0;
        #1;
        chk("init_tx", Rs232_Tx, 1);
        chk("init_done", Tx_Done, 0);
        chk("init_state", UART_state, 0);
        chk("init_full", Full, 0);
        chk("init_empty", Empty, 1);
        chk("init_level", Level, 0);
        chk("init_ovf", Overflow, 0);
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        repeat (2) @(negedge Clk);

        // Single word, latency and frame length at 115200.
        wr(8'h55, 1);
        @(negedge Clk);
        chk("lat_idle", Rs232_Tx, 1);
        chk("lat_level", Level, 1);
        recv(P115, 0, 1'b0, w);
        chk("lat_start", w, 1);
        chk("t1_state", UART_state, 0);
        chk("t1_empty", Empty, 1);

        // Burst of three, frames back-to-back.
        repeat (5) @(negedge Clk);
        wr(8'hA5, 1);
        @(negedge Clk);
        fork
            recv(P115, 0, 1'b0, w);
            begin
                wr(8'h3C, 1);
                wr(8'hFF, 1);
            end
        join
        chk("b2b_first", w, 1);
        recv(P115, 0, 1'b0, w);
        chk("b2b_gap2", w, 0);
        recv(P115, 0, 1'b0, w);
        chk("b2b_gap3", w, 0);
        chk("burst_empty", Empty, 1);
        chk("burst_state", UART_state, 0);
        chk("burst_tx", Rs232_Tx, 1);

        // Parity option.
        repeat (5) @(negedge Clk);
`ifdef UART_TX_PARITY_EN
        Parity_mode = 2'd1;
        wr(8'h07, 1);
        recv(P115, 1, 1'b1, w);
        repeat (5) @(negedge Clk);
        Parity_mode = 2'd2;
        wr(8'h07, 1);
        recv(P115, 1, 1'b0, w);
`else
        Parity_mode = 2'd1;
        wr(8'h07, 1);
        recv(P115, 0, 1'b0, w);
`endif
        Parity_mode = 2'd0;

        // Fill during a frame, overflow, push coincident with pop.
        repeat (5) @(negedge Clk);
        wr(8'h11, 0);
        c1 = cyc;
        repeat (3) @(negedge Clk);
        for (int i = 0; i < 16; i++) wr(8'h20 + 8'(i), 1);
        @(negedge Clk);
        chk("fill_level", Level, 16);
        chk("fill_full", Full, 1);
        chk("fill_empty", Empty, 0);
        chk("fill_ovf", Overflow, 0);
        wr(8'hEE, 0);
        @(negedge Clk);
        chk("ovf_pulse", Overflow, 1);
        chk("ovf_level", Level, 16);
        @(negedge Clk);
        chk("ovf_clear", Overflow, 0);
        while (cyc < c1 + 10 * P115) begin
            @(posedge Clk);
            #1;
        end
        Wr_data = 8'h5A;
        Wr_en   = 1'b1;
        @(posedge Clk);
        #1;
        Wr_en = 1'b0;
        sb.push_back(8'h5A);
        @(negedge Clk);
        chk("co_done", Tx_Done, 1);
        chk("co_level", Level, 16);
        chk("co_ovf", Overflow, 0);
        chk("co_start", Rs232_Tx, 0);
        recv(P115, 0, 1'b0, w);
        chk("co_gap", w, 0);
        do_reset();
        repeat (3) @(negedge Clk);

        // 9600 baud, mid-frame baud change, then reset mid-data.
        Baud_set = 3'd0;
        wr(8'h01, 0);
        c1 = cyc + 1;
        at_cyc(c1 + P9K6 - 1);
        chk("b0_start_end", Rs232_Tx, 0);
        at_cyc(c1 + P9K6);
        chk("b0_bit0", Rs232_Tx, 1);
        Baud_set = 3'd4;
        at_cyc(c1 + 2 * P9K6 - 1);
        chk("b0_bit0_end", Rs232_Tx, 1);
        at_cyc(c1 + 2 * P9K6);
        chk("b0_bit1", Rs232_Tx, 0);
        wr(8'hAA, 0);
        @(negedge Clk);
        chk("b0_level", Level, 1);
        at_cyc(c1 + 2 * P9K6 + 2000);
        chk("pre_rst_state", UART_state, 1);
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge Clk);
            if (Tx_Done !== 1'b0 || Rs232_Tx !== 1'b1) seen = 1'b1;
        end
        chk("post_rst_quiet", seen, 0);
        chk("post_rst_state", UART_state, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
